// File: rtl/crc_serial_engine.sv
// crc_serial_engine: parametrised serial CRC generator/checker with run-time frame length
module crc_serial_engine #(
  parameter int CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY = 15'h4599,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic [CRC_W-1:0] crc_out,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err
);
  localparam int CW = $clog2(CRC_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, CRCP, DONE} state_t;
  state_t state, nxt;
  logic mode_r;
  logic [LEN_W-1:0] len_r, bit_cnt;
  logic [CW-1:0] crc_cnt;
  logic [CRC_W-1:0] lfsr, step, shl;
  logic last_d, last_c;
  always_comb begin
    shl = {lfsr[CRC_W-2:0], 1'b0};
    step = shl ^ ((din ^ lfsr[CRC_W-1]) ? POLY : '0);
    last_d = din_valid && bit_cnt == len_r - LEN_W'(1);
    last_c = din_valid && crc_cnt == CW'(CRC_W - 1);
    busy = state != IDLE;
    done = state == DONE;
    tx_valid = state == CRCP && !mode_r;
    tx_bit = tx_valid && lfsr[CRC_W-1];
    nxt = state;
    case (state)
      IDLE: nxt = start ? (len == '0 ? CRCP : DATA) : IDLE;
      DATA: nxt = last_d ? CRCP : DATA;
      CRCP: nxt = last_c ? DONE : CRCP;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_r <= 1'b0;
      len_r <= '0;
      lfsr <= INIT;
      bit_cnt <= '0;
      crc_cnt <= '0;
      crc_out <= '0;
      crc_ok <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          mode_r <= mode;
          len_r <= len;
          lfsr <= INIT;
          bit_cnt <= '0;
          crc_cnt <= '0;
          crc_out <= len == '0 ? INIT : '0;
          crc_ok <= 1'b0;
          crc_err <= 1'b0;
        end
        DATA: if (din_valid) begin
          lfsr <= step;
          bit_cnt <= bit_cnt + LEN_W'(1);
          crc_cnt <= '0;
          if (last_d) crc_out <= step;
        end
        CRCP: if (din_valid) begin
          lfsr <= mode_r ? step : shl;
          crc_cnt <= crc_cnt + CW'(1);
          if (last_c) begin
            crc_ok <= mode_r && step == '0;
            crc_err <= mode_r && step != '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: scoreboard bench for the CAN CRC-15 and an 8-bit instance
module tb_crc_serial_engine;
  logic clk = 0;
  logic rst = 1, start15 = 0, start8 = 0, mode = 0, din = 0, din_valid = 0;
  logic [15:0] len = '0;
  logic busy, tx_bit, tx_valid, done, crc_ok, crc_err;
  logic [14:0] crc_out;
  logic busy8, tx_bit8, tx_valid8, done8, crc_ok8, crc_err8;
  logic [7:0] crc_out8;
  typedef struct {
    logic [14:0] crc;
    bit chk_crc;
    bit ok;
    bit err;
    int n;
  } res_t;
  res_t q15[$], q8[$];
  bit qtx15[$], qtx8[$];
  int n15 = 0, n8 = 0, total = 0, bad = 0;
  res_t r15, r8;
  crc_serial_engine dut (
    .clk(clk), .rst(rst), .start(start15), .mode(mode), .len(len), .din(din),
    .din_valid(din_valid), .busy(busy), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .crc_out(crc_out), .done(done), .crc_ok(crc_ok), .crc_err(crc_err)
  );
  crc_serial_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .LEN_W(16)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode), .len(len), .din(din),
    .din_valid(din_valid), .busy(busy8), .tx_bit(tx_bit8), .tx_valid(tx_valid8),
    .crc_out(crc_out8), .done(done8), .crc_ok(crc_ok8), .crc_err(crc_err8)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst === 1'b0) begin
    if (start15 && !busy) n15 = 0;
    else if (busy && din_valid && !done) n15++;
    if (start8 && !busy8) n8 = 0;
    else if (busy8 && din_valid && !done8) n8++;
    if (tx_valid && din_valid) begin
      if (qtx15.size() == 0) check("tx15_extra", 1, 0);
      else check("tx15", tx_bit, qtx15.pop_front());
    end
    if (tx_valid8 && din_valid) begin
      if (qtx8.size() == 0) check("tx8_extra", 1, 0);
      else check("tx8", tx_bit8, qtx8.pop_front());
    end
    if (done) begin
      if (q15.size() == 0) check("done15_spurious", 1, 0);
      else begin
        r15 = q15.pop_front();
        if (r15.chk_crc) check("crc15", crc_out, r15.crc);
        check("ok15", crc_ok, r15.ok);
        check("err15", crc_err, r15.err);
        check("strobes15", n15, r15.n);
      end
    end
    if (done8) begin
      if (q8.size() == 0) check("done8_spurious", 1, 0);
      else begin
        r8 = q8.pop_front();
        if (r8.chk_crc) check("crc8", crc_out8, {24'b0, r8.crc[7:0]});
        check("ok8", crc_ok8, r8.ok);
        check("err8", crc_err8, r8.err);
        check("strobes8", n8, r8.n);
      end
    end
  end
  task automatic pulse_start(bit s8, bit m, int l, bit with_strobe);
    mode = m;
    len = 16'(l);
    start15 = !s8;
    start8 = s8;
    din = 1'b1;
    din_valid = with_strobe;
    @(posedge clk);
    #1 start15 = 0;
    start8 = 0;
    din_valid = 0;
  endtask
  task automatic send(bit s8, logic [63:0] s, int ns, int g, int inj);
    for (int i = 0; i < ns; i++) begin
      repeat (g - 1) begin
        @(posedge clk);
        #1;
      end
      check("busy_held", s8 ? busy8 : busy, 1);
      din = s[ns-1-i];
      din_valid = 1;
      if (i == inj) begin
        if (s8) start8 = 1;
        else start15 = 1;
        mode = ~mode;
        len = 16'd3;
      end
      @(posedge clk);
      #1 din_valid = 0;
      start15 = 0;
      start8 = 0;
    end
    @(negedge clk);
    check("done_latency", s8 ? done8 : done, 1);
    @(posedge clk);
    #1;
    check("busy_off", s8 ? busy8 : busy, 0);
    check("done_pulse", s8 ? done8 : done, 0);
  endtask
  task automatic frame(bit s8, bit m, int l, logic [63:0] s, int g, int inj, bit sw,
                       logic [14:0] ecrc, bit chkc, bit eok, bit eerr);
    int cw;
    res_t r;
    cw = s8 ? 8 : 15;
    r.crc = ecrc;
    r.chk_crc = chkc;
    r.ok = eok;
    r.err = eerr;
    r.n = l + cw;
    if (s8) q8.push_back(r);
    else q15.push_back(r);
    if (!m) for (int k = cw - 1; k >= 0; k--) begin
      if (s8) qtx8.push_back(ecrc[k]);
      else qtx15.push_back(ecrc[k]);
    end
    pulse_start(s8, m, l, sw);
    send(s8, s, l + cw, g, inj);
  endtask
  initial begin
    logic [63:0] good;
    int flips[4];
    flips = '{0, 7, 20, 30};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_crc_out", crc_out, 0);
    check("rst_ok_err", {crc_ok, crc_err}, 0);
    check("rst_crc_out8", crc_out8, 0);
    frame(0, 0, 16, 64'({16'hABCD, 15'h2AAA}), 1, -1, 0, 15'h1C4F, 1, 0, 0);
    good = 64'({16'hABCD, 15'h1C4F});
    frame(0, 1, 16, good, 1, -1, 0, 15'h1C4F, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1 check("ok_hold", {crc_ok, crc_err}, 2'b10);
    check("crc_out_hold", crc_out, 15'h1C4F);
    foreach (flips[j])
      frame(0, 1, 16, good ^ (64'd1 << flips[j]), 1, -1, 0, 15'h1C4F, flips[j] < 15, 0, 1);
    frame(0, 0, 1, 64'({1'b1, 15'h1234}), 1, -1, 0, 15'h4599, 1, 0, 0);
    frame(0, 0, 0, 64'h7FFF, 1, -1, 0, 15'h0000, 1, 0, 0);
    frame(0, 0, 16, 64'({16'hABCD, 15'h0F0F}), 3, -1, 0, 15'h1C4F, 1, 0, 0);
    pulse_start(0, 0, 16, 0);
    for (int i = 0; i < 8; i++) begin
      din = i[0];
      din_valid = 1;
      @(posedge clk);
      #1 din_valid = 0;
    end
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_crc_out", crc_out, 0);
    check("midrst_ok_err", {crc_ok, crc_err}, 0);
    frame(0, 0, 16, 64'({16'hABCD, 15'h2AAA}), 1, 5, 0, 15'h1C4F, 1, 0, 0);
    frame(0, 1, 16, good, 1, 20, 1, 15'h1C4F, 1, 1, 0);
    frame(1, 0, 8, 64'({8'h01, 8'hFF}), 1, -1, 0, 15'h0007, 1, 0, 0);
    frame(1, 1, 8, 64'({8'h01, 8'h07}), 1, -1, 0, 15'h0007, 1, 1, 0);
    frame(1, 1, 8, 64'({8'h01, 8'h05}), 1, -1, 0, 15'h0007, 1, 0, 1);
    repeat (2) @(posedge clk);
    check("tx15_left", qtx15.size(), 0);
    check("tx8_left", qtx8.size(), 0);
    check("res15_left", q15.size(), 0);
    check("res8_left", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
